dma_line_writer: RTL and testbench
==================================

# dma_line_writer

Bus-mastering DMA initiator for the pipelined CPU's data-memory port. It takes a transfer command from the CPU, gets the shared data bus through a BR/BG handshake, and fetches 64-bit lines from an external device buffer. Each line is written into memory as a full-line write, with address and data held stable for the memory's required settle window. It ends each transfer with a one-cycle `dma_end` interrupt pulse.

## Interface
- `WORD_SIZE`, 16, memory word width
- `LINE_SIZE`, 64, line width (4 words)
- `MEM_LATENCY`, 4, consecutive rising edges a memory request must stay stable before it commits
- `clk  in  1  system clock`
- `reset_n  in  1  asynchronous, active-low reset`
- `cmd_valid  in  1  start pulse from CPU`
- `cmd_addr  in  WORD_SIZE  destination base word address`
- `cmd_length  in  WORD_SIZE  transfer length in words`
- `cmd_ready  out  1  high when idle and able to accept a command`
- `BR  out  1  bus request`
- `BG  in  1  bus grant from CPU`
- `dma_end  out  1  one-cycle completion pulse`
- `dev_rd  out  1  line fetch request to device`
- `dev_idx  out  WORD_SIZE-2  line index within transfer (0-based)`
- `dev_valid  in  1  device line data valid`
- `dev_data  in  LINE_SIZE  device line; word 0 in bits [15:0]`
- `d_readM  out  1  memory read enable; driven 0 when owning bus, else Z`
- `d_writeM  out  1  memory write enable; Z when not owning bus`
- `d_writeMword  out  1  driven 0 (line write) when owning bus, else Z`
- `d_address  out  WORD_SIZE  memory word address; Z when not owning bus`
- `d_data  inout  LINE_SIZE  write data; driven only while owning bus, else Z`

## Operation
- States: IDLE, REQ, FETCH, WRITE, DONE; with the macro enabled, also RELEASE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `cmd_addr`. Set line count N = `cmd_length[15:2]`; the low 2 bits are dropped.
  - If N=0, go to DONE without asserting BR. Otherwise go to REQ.
- REQ: `BR`=1. On `BG`=1, go to FETCH.
- FETCH:
  - Assert `dev_rd` with `dev_idx`=current line until `dev_valid`.
  - On `dev_valid`, latch `dev_data` and go to WRITE.
- WRITE:
  - Own the bus: `d_writeM`=1, `d_readM`=0, `d_writeMword`=0.
  - `d_address` = base + 4·idx, modulo 2^16, so addresses wrap past 0xFFFC.
  - `d_data` = latched line; memory stores word k at address+k from bits [16k+15:16k].
  - Hold exactly `MEM_LATENCY` cycles, then increment idx.
  - If idx = N, go to DONE. Otherwise go to FETCH, or to RELEASE when the macro is enabled.
- DONE: pulse `dma_end` for one cycle, drop `BR`, return to IDLE.
- Bus ownership = `BG` && state ∈ {FETCH, WRITE}. All `d_*` outputs are high-Z otherwise.
- `cmd_valid` while not IDLE is ignored.
- `BG` falling while in FETCH or WRITE:
  - Release the bus immediately.
  - Keep the latched line and idx, and return to REQ.
  - The WRITE hold counter restarts from 0 after re-grant.
- `dev_valid` outside FETCH is ignored.

## Timing
- Reset values:
  - `BR`=0, `dma_end`=0, `dev_rd`=0, `dev_idx`=0, `cmd_ready`=1.
  - All `d_*` outputs high-Z; state IDLE.
- Asynchronous reset mid-transfer aborts the transfer immediately with no `dma_end` pulse. A partially held line must not be considered written.
- `cmd_valid` at edge t → `BR`=1 after edge t (REQ), or `dma_end`=1 in cycle t+1 when N=0.
- `BG` sampled at edge → `dev_rd` high in the following cycle.
- `dev_valid` at edge e → `d_writeM` and `d_address` valid from e to e+`MEM_LATENCY`; the line commits at the `MEM_LATENCY`-th edge.
- Consecutive lines in burst mode: the address changes on the same edge that ends the previous hold, so the next `dev_rd` is issued that cycle.
- `BR` falls in the cycle `dma_end` is high; `dma_end` is never high for two cycles.
- Minimum transfer of one line with 0-cycle grant and device delay: REQ 1 + FETCH 1 + WRITE `MEM_LATENCY` + DONE 1.

## Configuration
- `DMA_CYCLE_STEAL_EN` defined:
  - After each non-final line, enter RELEASE: `BR`=0 and bus Z for one cycle.
  - Then return to REQ, giving the CPU a slot between lines.
- Undefined: burst mode. `BR` is held from REQ through DONE and there is no RELEASE state.

## Test plan
- `cmd_addr`=0x1F4, `cmd_length`=12, `BG` after 1 cycle, `dev_valid` immediate:
  - Three line writes, at 0x1F4, 0x1F8 and 0x1FC, each held exactly 4 cycles.
  - Memory words match `dev_data` word order; one `dma_end` pulse; `BR` low afterward.
- `cmd_length`=6 → exactly one line written; `cmd_length`=3 → no `BR`, `dma_end` in the next cycle.
- `BG` delayed 5 cycles → all `d_*` outputs stay Z until grant; transfer otherwise identical.
- `BG` dropped at WRITE cycle 2 and restored 3 cycles later:
  - Bus goes Z immediately.
  - Same address is rewritten with a fresh 4-cycle hold; memory data is correct.
- `cmd_valid` with new parameters mid-transfer → ignored; the original transfer completes unchanged.
- `cmd_addr`=0xFFFC, length 8 → writes at 0xFFFC and then 0x0000.
- With `DMA_CYCLE_STEAL_EN` → a 1-cycle `BR`=0 gap between lines, with no gap before the first line or after the last.

Source files
------------

// File: rtl/dma_line_writer.sv
// DMA initiator: wins the bus via BR/BG, fetches 64-bit device lines, writes each as a held full-line store, then pulses dma_end.
// Defining DMA_CYCLE_STEAL_EN drops BR for one cycle between lines (cycle stealing); otherwise the bus is held for the whole burst.
module dma_line_writer #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_SIZE   = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_length,
  output logic                 cmd_ready,
  output logic                 BR,
  input  logic                 BG,
  output logic                 dma_end,
  output logic                 dev_rd,
  output logic [WORD_SIZE-3:0] dev_idx,
  input  logic                 dev_valid,
  input  logic [LINE_SIZE-1:0] dev_data,
  output wire                  d_readM,
  output wire                  d_writeM,
  output wire                  d_writeMword,
  output wire  [WORD_SIZE-1:0] d_address,
  inout  wire  [LINE_SIZE-1:0] d_data
);

  localparam int IW = WORD_SIZE - 2;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
`ifdef DMA_CYCLE_STEAL_EN
  localparam logic [2:0] S_RELEASE = 3'd5;
`endif

  logic [2:0]           state;
  logic [WORD_SIZE-1:0] base_addr;
  logic [IW-1:0]        n_lines;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_next;
  logic [LINE_SIZE-1:0] line;
  logic                 line_held;
  logic [CW-1:0]        hold;
  logic [WORD_SIZE-1:0] line_addr;
  logic                 own;
  logic                 unused_len;

  // Sub-line length bits are deliberately discarded: only whole lines move.
  assign unused_len = ^cmd_length[1:0];
  assign idx_next   = idx + IW'(1);
  assign line_addr  = base_addr + {idx, 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      base_addr <= '0;
      n_lines   <= '0;
      idx       <= '0;
      line      <= '0;
      line_held <= 1'b0;
      hold      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            base_addr <= cmd_addr;
            n_lines   <= cmd_length[WORD_SIZE-1:2];
            idx       <= '0;
            line_held <= 1'b0;
            state     <= (cmd_length[WORD_SIZE-1:2] == '0) ? S_DONE : S_REQ;
          end
        end
        S_REQ: begin
          // A line latched before a grant loss is rewritten without refetching.
          if (BG) begin
            hold  <= '0;
            state <= line_held ? S_WRITE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (!BG) begin
            state <= S_REQ;
          end else if (dev_valid) begin
            line      <= dev_data;
            line_held <= 1'b1;
            hold      <= '0;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!BG) begin
            hold  <= '0;
            state <= S_REQ;
          end else if (hold == CW'(MEM_LATENCY - 1)) begin
            hold      <= '0;
            idx       <= idx_next;
            line_held <= 1'b0;
            if (idx_next == n_lines) begin
              state <= S_DONE;
            end else begin
`ifdef DMA_CYCLE_STEAL_EN
              state <= S_RELEASE;
`else
              state <= S_FETCH;
`endif
            end
          end else begin
            hold <= hold + CW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
`ifdef DMA_CYCLE_STEAL_EN
        S_RELEASE: state <= S_REQ;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign own       = BG && ((state == S_FETCH) || (state == S_WRITE));
  assign cmd_ready = (state == S_IDLE);
  assign BR        = (state == S_REQ) || (state == S_FETCH) || (state == S_WRITE);
  assign dma_end   = (state == S_DONE);
  assign dev_rd    = (state == S_FETCH) && BG;
  assign dev_idx   = idx;

  assign d_readM      = own ? 1'b0 : 1'bz;
  assign d_writeM     = own ? (state == S_WRITE) : 1'bz;
  assign d_writeMword = own ? 1'b0 : 1'bz;
  assign d_address    = own ? line_addr : {WORD_SIZE{1'bz}};
  assign d_data       = own ? line : {LINE_SIZE{1'bz}};

endmodule

// File: tb/tb_dma_line_writer.sv
// Bench for dma_line_writer: random and directed transfers against a word-level memory and timing model.
module tb_dma_line_writer;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_length = '0;
  logic        BG = 1'b0;
  logic        dev_valid = 1'b0;
  logic [63:0] dev_data = '0;
  wire         cmd_ready, BR, dma_end, dev_rd;
  wire  [13:0] dev_idx;
  wire         d_readM, d_writeM, d_writeMword;
  wire  [15:0] d_address;
  wire  [63:0] d_data;

  // Pulls make a released bus observable: read/word enables float high, write enable low.
  pullup   (d_readM);
  pullup   (d_writeMword);
  pulldown (d_writeM);

  dma_line_writer #(.WORD_SIZE(16), .LINE_SIZE(64), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_length(cmd_length), .cmd_ready(cmd_ready), .BR(BR), .BG(BG),
    .dma_end(dma_end), .dev_rd(dev_rd), .dev_idx(dev_idx), .dev_valid(dev_valid),
    .dev_data(dev_data), .d_readM(d_readM), .d_writeM(d_writeM),
    .d_writeMword(d_writeMword), .d_address(d_address), .d_data(d_data)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] dev_lines [64];
  logic [15:0] exp_q [$];
  logic [15:0] mem [int];
  int          gdelay = 0;
  int          ddelay = 0;
  bit          drop_armed = 1'b0;
  int          wcnt = 0;
  int          end_cnt = 0;
  int          br_rises = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Bus arbiter: grants after gdelay cycles of BR; can yank BG for 3 cycles in the 2nd write cycle.
  initial begin
    int gcnt = 0;
    int off = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || !BR) begin
        BG = 1'b0; gcnt = 0; off = 0;
      end else if (drop_armed && d_writeM === 1'b1 && ++wcnt == 2) begin
        BG = 1'b0; off = 2; gcnt = 0; drop_armed = 1'b0;
      end else if (off > 0) begin
        off--;
      end else if (!BG) begin
        if (gcnt >= gdelay) BG = 1'b1;
        else gcnt++;
      end
    end
  end

  // Device: answers a fetch after ddelay cycles with the stored line for dev_idx.
  initial begin
    int dcnt = 0;
    forever begin
      @(posedge clk); #2;
      dev_valid = 1'b0;
      if (dev_rd === 1'b1) begin
        if (dcnt >= ddelay) begin
          dev_valid = 1'b1;
          dev_data  = dev_lines[dev_idx[5:0]];
          dcnt = 0;
        end else dcnt++;
      end else dcnt = 0;
    end
  end

  // Monitor: bus release, dma_end shape, and a memory that commits after L stable write cycles.
  initial begin
    int run_len = 0;
    logic [15:0] run_addr = '0;
    logic [63:0] run_dat = '0;
    logic [15:0] a;
    bit end_prev = 1'b0;
    bit br_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run_len = 0; end_prev = 1'b0; br_prev = 1'b0;
      end else begin
        if (!BG || !BR) begin
          chk("bus_released_readM", d_readM, 1);
          chk("bus_released_wordM", d_writeMword, 1);
        end
        if (dma_end) begin
          end_cnt++;
          chk("br_low_at_end", BR, 0);
          chk("end_single_cycle", end_prev, 0);
        end
        end_prev = dma_end;
        if (BR && !br_prev) br_rises++;
        br_prev = BR;
        if (d_writeM === 1'b1) begin
          if (run_len > 0 && d_address == run_addr && d_data == run_dat) run_len++;
          else begin
            run_len = 1; run_addr = d_address; run_dat = d_data;
          end
          if (run_len == L) begin
            for (int k = 0; k < 4; k++) begin
              a = run_addr + 16'(k);
              mem[int'(a)] = run_dat[16*k +: 16];
            end
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else chk("write_addr", run_addr, exp_q.pop_front());
          end
          if (run_len > L) chk("hold_len", run_len, L);
        end else run_len = 0;
      end
    end
  end

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 16'h0;
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] len);
    for (int t = 0; t < 100 && !cmd_ready; t++) begin
      @(posedge clk); #1;
    end
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_length = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_length = 16'($urandom);
  endtask

  task automatic run_xfer(input logic [15:0] a, input logic [15:0] len,
                          input int g, input int d, input bit drop, input bit mid);
    int n = int'(len[15:2]);
    int exp_lat;
    int exp_rises;
    int lat = 0;
    bit done = 1'b0;
    logic [15:0] la;
    gdelay = g; ddelay = d; wcnt = 0; drop_armed = drop;
    mem.delete(); exp_q.delete(); end_cnt = 0; br_rises = 0;
    for (int i = 0; i < n; i++) begin
      dev_lines[i] = {$urandom, $urandom};
      exp_q.push_back(a + 16'(4 * i));
    end
    exp_lat   = (n == 0) ? 1 : (1 + g) + n * (1 + d + L) + 1;
    exp_rises = (n == 0) ? 0 : 1;
`ifdef DMA_CYCLE_STEAL_EN
    if (n > 1) exp_lat += (n - 1) * (2 + g);
    exp_rises = n;
`endif
    @(negedge clk);
    issue(a, len);
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      lat++;
      if (dma_end) done = 1'b1;
      else if (mid && lat == 3 && exp_lat >= 8) begin
        cmd_valid = 1'b1; cmd_addr = 16'($urandom); cmd_length = 16'($urandom_range(4, 200));
      end else cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("dma_end_seen", done, 1);
    if (!drop) chk("latency", lat, exp_lat);
    @(negedge clk); @(negedge clk);
    chk("br_after_done", BR, 0);
    chk("cmd_ready_after_done", cmd_ready, 1);
    chk("end_pulses", end_cnt, 1);
    chk("lines_left", exp_q.size(), 0);
    chk("br_rises", br_rises, exp_rises);
    for (int i = 0; i < n; i++) begin
      la = a + 16'(4 * i);
      chk("mem_line", {rd(la + 16'd3), rd(la + 16'd2), rd(la + 16'd1), rd(la)}, dev_lines[i]);
    end
    if (n == 0) chk("no_mem_write", mem.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_BR", BR, 0);
    chk("rst_dma_end", dma_end, 0);
    chk("rst_dev_rd", dev_rd, 0);
    chk("rst_dev_idx", dev_idx, 0);
    chk("rst_readM_z", d_readM, 1);
    chk("rst_wordM_z", d_writeMword, 1);
    chk("rst_writeM_z", d_writeM, 0);
    reset_n = 1'b1;

    run_xfer(16'h01F4, 16'd12, 1, 0, 0, 0);
    run_xfer(16'h0040, 16'd6,  0, 0, 0, 0);
    run_xfer(16'h0080, 16'd3,  0, 0, 0, 0);
    run_xfer(16'h0200, 16'd8,  5, 0, 0, 0);
    run_xfer(16'h0300, 16'd8,  0, 0, 1, 0);
    run_xfer(16'h0400, 16'd16, 1, 1, 0, 1);
    run_xfer(16'hFFFC, 16'd8,  0, 0, 0, 0);
    for (int r = 0; r < 20; r++) begin
      logic [15:0] len = 16'($urandom_range(0, 40));
      run_xfer(16'($urandom), len, $urandom_range(0, 3), $urandom_range(0, 3),
               (len >= 4) && ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of the first line's hold: no pulse, nothing committed.
    mem.delete(); exp_q.delete(); end_cnt = 0; gdelay = 0; ddelay = 0;
    for (int i = 0; i < 2; i++) dev_lines[i] = {$urandom, $urandom};
    @(negedge clk);
    issue(16'h0500, 16'd8);
    hits = 0;
    for (int t = 0; t < 200 && hits < 2; t++) begin
      @(negedge clk);
      if (d_writeM === 1'b1) hits++;
    end
    chk("reached_write", hits, 2);
    reset_n = 1'b0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_BR", BR, 0);
    chk("arst_dma_end", dma_end, 0);
    chk("arst_bus_z", d_readM, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_end", end_cnt, 0);
    chk("arst_no_commit", mem.size(), 0);
    exp_q.delete();
    run_xfer(16'h0600, 16'd8, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
